// File: rtl/lsu_if.sv
// Word-wide request/acknowledge data-memory bus between the load/store unit
// (master) and the data memory (slave).
interface lsu_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [3:0]        mem_wstrb_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_wstrb_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_wstrb_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: runs one load or store per access over a req/ack bus,
// stalls the core meanwhile, steers byte lanes, extends loads, flags faults.
module lsu #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic [1:0]        ResultSrc,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    lsu_if.master             bus
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [1:0]        r_off;
    logic [2:0]        r_funct3;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_load_data;
    logic              r_misalign;
    logic              r_bus_err;

    logic        w_is_store;
    logic        w_is_load;
    logic        w_access;
    logic        w_legal;
    logic        w_misaligned;
    logic        w_fault_in;
    logic        w_start;
    logic        w_fault;
    logic        w_ack;
    logic        w_tmo;
    logic        w_stall;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_ext;

    // Access decode: a store takes priority over a simultaneous load.
    assign w_is_store = MemWrite;
    assign w_is_load  = !MemWrite && (ResultSrc == 2'b01);
    assign w_access   = w_is_store || w_is_load;

    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = w_is_load;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   w_misaligned = addr_i[0];
            2'b10:   w_misaligned = (addr_i[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_fault_in = !w_legal || w_misaligned;

    // Store lane steering: replicate the datum across the word, strobe the lanes.
    always_comb begin
        w_wdata = wdata_i;
        w_wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{wdata_i[7:0]}};
                w_wstrb = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                w_wdata = {2{wdata_i[15:0]}};
                w_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = wdata_i;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Load extraction from the returned word using the latched offset and size.
    always_comb begin
        w_rd_byte = bus.mem_rdata_i[7:0];
        case (r_off)
            2'd1:    w_rd_byte = bus.mem_rdata_i[15:8];
            2'd2:    w_rd_byte = bus.mem_rdata_i[23:16];
            2'd3:    w_rd_byte = bus.mem_rdata_i[31:24];
            default: w_rd_byte = bus.mem_rdata_i[7:0];
        endcase
        w_rd_half = r_off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_rd_byte[7]}}, w_rd_byte};
            3'b001:  w_load_ext = {{16{w_rd_half[15]}}, w_rd_half};
            3'b100:  w_load_ext = {24'd0, w_rd_byte};
            3'b101:  w_load_ext = {16'd0, w_rd_half};
            default: w_load_ext = bus.mem_rdata_i;
        endcase
    end

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_fault      = 1'b0;
        w_ack        = 1'b0;
        w_tmo        = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall = 1'b1;
                    if (w_fault_in) begin
                        w_fault      = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_start      = 1'b1;
                        w_state_next = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                w_stall = 1'b1;
                // Ack wins over a timeout landing in the same cycle.
                if (bus.mem_ack_i) begin
                    w_ack        = 1'b1;
                    w_state_next = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_tmo        = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= 4'b0000;
            r_off       <= 2'b00;
            r_funct3    <= 3'b000;
            r_cnt       <= '0;
            r_load_data <= '0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_misalign <= w_fault;
            r_bus_err  <= w_tmo;

            if (w_start) begin
                r_req    <= 1'b1;
                r_we     <= w_is_store;
                r_addr   <= {addr_i[ADDR_W-1:2], 2'b00};
                r_wdata  <= w_wdata;
                r_wstrb  <= w_is_store ? w_wstrb : 4'b0000;
                r_off    <= addr_i[1:0];
                r_funct3 <= funct3;
                r_cnt    <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_ack || w_tmo) begin
                    r_req <= 1'b0;
                end
            end

            // Completed stores leave the last load result untouched.
            if (w_ack && !r_we) begin
                r_load_data <= w_load_ext;
            end else if (w_tmo && !r_we) begin
                r_load_data <= '0;
            end else if (w_fault && !w_is_store) begin
                r_load_data <= '0;
            end
        end
    end

    assign stall_o         = !rst && w_stall;
    assign load_data_o     = r_load_data;
    assign misalign_o      = r_misalign;
    assign bus_err_o       = r_bus_err;
    assign bus.mem_req_o   = r_req;
    assign bus.mem_we_o    = r_we;
    assign bus.mem_addr_o  = r_addr;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.mem_wstrb_o = r_wstrb;

endmodule
